// File: rtl/cache_tag_plru_if.sv
// Request/response bundle of the set-associative tag store with tree-PLRU replacement.
// The slave side is the tag store; the master side issues requests and flushes.
interface cache_tag_plru_if #(
  parameter int WAYS  = 4,
  parameter int SETS  = 1024,
  parameter int TAG_W = 20
);
  localparam int IW = $clog2(SETS);
  localparam int WW = $clog2(WAYS);

  logic             req_valid_i;
  logic             req_ready_o;
  logic [1:0]       req_op_i;
  logic [IW-1:0]    req_index_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             req_dirty_i;
  logic             flush_i;
  logic             rsp_valid_o;
  logic             rsp_hit_o;
  logic [WW-1:0]    rsp_way_o;
  logic [TAG_W-1:0] rsp_victim_tag_o;
  logic             rsp_victim_valid_o;
  logic             rsp_victim_dirty_o;
  logic             rsp_full_o;
  logic             busy_o;

  modport master (
    output req_valid_i, req_op_i, req_index_i, req_tag_i, req_dirty_i, flush_i,
    input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_victim_tag_o,
           rsp_victim_valid_o, rsp_victim_dirty_o, rsp_full_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_index_i, req_tag_i, req_dirty_i, flush_i,
    output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_victim_tag_o,
           rsp_victim_valid_o, rsp_victim_dirty_o, rsp_full_o, busy_o
  );
endinterface

// File: rtl/cache_tag_plru.sv
// Tag/valid/dirty store with per-set tree-PLRU replacement. Requests are resolved in the
// accept cycle and answered one cycle later; a sweep clears all sets after reset or flush.
module cache_tag_plru #(
  parameter int WAYS  = 4,
  parameter int SETS  = 1024,
  parameter int TAG_W = 20
) (
  input logic             clk_i,
  input logic             rst_ni,
  cache_tag_plru_if.slave bus
);
  localparam int IW = $clog2(SETS);
  localparam int WW = $clog2(WAYS);
  localparam int NN = WAYS - 1;
  localparam int NW = (NN > 1) ? $clog2(NN) : 1;

  localparam logic [1:0] OP_LOOKUP    = 2'b00;
  localparam logic [1:0] OP_LOOKUP_WR = 2'b01;
  localparam logic [1:0] OP_FILL      = 2'b10;
  localparam logic [1:0] OP_INVAL     = 2'b11;

  typedef enum logic {S_SWEEP, S_READY} state_t;

  state_t           r_state;
  logic [IW-1:0]    r_sweep_cnt;
  logic             r_ready;
  logic             r_busy;

  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAYS-1:0]  r_dirty [SETS];
  logic [NN-1:0]    r_plru  [SETS];

  logic             r_vld_p1;
  logic             r_hit_p1;
  logic [WW-1:0]    r_way_p1;
  logic [TAG_W-1:0] r_vic_tag_p1;
  logic             r_vic_valid_p1;
  logic             r_vic_dirty_p1;
  logic             r_full_p1;

  // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
  function automatic logic [WW-1:0] plru_victim(input logic [NN-1:0] bits);
    logic [WW-1:0] way;
    logic [NW-1:0] node;
    way  = '0;
    node = '0;
    for (int l = 0; l < WW; l++) begin
      way[WW-1-l] = bits[node];
      node        = NW'(2 * int'(node) + 1 + int'(bits[node]));
    end
    return way;
  endfunction

  function automatic logic [NN-1:0] plru_touch(input logic [NN-1:0] bits,
                                               input logic [WW-1:0] way);
    logic [NN-1:0] nxt;
    logic [NW-1:0] node;
    logic          b;
    nxt  = bits;
    node = '0;
    for (int l = 0; l < WW; l++) begin
      b         = way[WW-1-l];
      nxt[node] = ~b;
      node      = NW'(2 * int'(node) + 1 + int'(b));
    end
    return nxt;
  endfunction

  logic             w_accept_p0;
  logic [IW-1:0]    w_idx_p0;
  logic [WAYS-1:0]  w_valid_p0;
  logic [WAYS-1:0]  w_dirty_p0;
  logic [NN-1:0]    w_plru_p0;
  logic             w_hit_p0;
  logic [WW-1:0]    w_hit_way_p0;
  logic             w_has_inv_p0;
  logic [WW-1:0]    w_inv_way_p0;
  logic [WW-1:0]    w_tgt_p0;
  logic             w_vic_en_p0;
  logic [TAG_W-1:0] w_vic_tag_p0;
  logic             w_vic_valid_p0;
  logic             w_vic_dirty_p0;

  // p0: lookup of the addressed set in the accept cycle
  always_comb begin
    w_accept_p0  = rst_ni & bus.req_valid_i & r_ready;
    w_idx_p0     = bus.req_index_i;
    w_valid_p0   = r_valid[w_idx_p0];
    w_dirty_p0   = r_dirty[w_idx_p0];
    w_plru_p0    = r_plru[w_idx_p0];
    w_hit_p0     = 1'b0;
    w_hit_way_p0 = '0;
    w_has_inv_p0 = 1'b0;
    w_inv_way_p0 = '0;
    // Descending scan so the lowest matching index is the one kept.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_valid_p0[w] && (r_tag[w_idx_p0][w] == bus.req_tag_i)) begin
        w_hit_p0     = 1'b1;
        w_hit_way_p0 = WW'(w);
      end
      if (!w_valid_p0[w]) begin
        w_has_inv_p0 = 1'b1;
        w_inv_way_p0 = WW'(w);
      end
    end
    if (w_hit_p0)          w_tgt_p0 = w_hit_way_p0;
    else if (w_has_inv_p0) w_tgt_p0 = w_inv_way_p0;
    else                   w_tgt_p0 = plru_victim(w_plru_p0);

    w_vic_en_p0    = (bus.req_op_i == OP_FILL) || ((bus.req_op_i == OP_INVAL) && w_hit_p0);
    w_vic_valid_p0 = w_vic_en_p0 & w_valid_p0[w_tgt_p0];
    w_vic_dirty_p0 = w_vic_valid_p0 & w_dirty_p0[w_tgt_p0];
    w_vic_tag_p0   = w_vic_valid_p0 ? r_tag[w_idx_p0][w_tgt_p0] : '0;
  end

  // Set state: sweep clears one set per cycle, otherwise the accepted request updates its set.
  always_ff @(posedge clk_i) begin
    if (r_state == S_SWEEP) begin
      r_valid[r_sweep_cnt] <= '0;
      r_dirty[r_sweep_cnt] <= '0;
      r_plru[r_sweep_cnt]  <= '0;
    end else if (w_accept_p0) begin
      case (bus.req_op_i)
        OP_LOOKUP: begin
          if (w_hit_p0) r_plru[w_idx_p0] <= plru_touch(w_plru_p0, w_hit_way_p0);
        end
        OP_LOOKUP_WR: begin
          if (w_hit_p0) begin
            r_plru[w_idx_p0]                <= plru_touch(w_plru_p0, w_hit_way_p0);
            r_dirty[w_idx_p0][w_hit_way_p0] <= 1'b1;
          end
        end
        OP_FILL: begin
          r_tag[w_idx_p0][w_tgt_p0]   <= bus.req_tag_i;
          r_valid[w_idx_p0][w_tgt_p0] <= 1'b1;
          r_dirty[w_idx_p0][w_tgt_p0] <= bus.req_dirty_i;
          r_plru[w_idx_p0]            <= plru_touch(w_plru_p0, w_tgt_p0);
        end
        OP_INVAL: begin
          if (w_hit_p0) begin
            r_valid[w_idx_p0][w_hit_way_p0] <= 1'b0;
            r_dirty[w_idx_p0][w_hit_way_p0] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // p1: registered response and sweep/ready control
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state        <= S_SWEEP;
      r_sweep_cnt    <= '0;
      r_ready        <= 1'b0;
      r_busy         <= 1'b1;
      r_vld_p1       <= 1'b0;
      r_hit_p1       <= 1'b0;
      r_way_p1       <= '0;
      r_vic_tag_p1   <= '0;
      r_vic_valid_p1 <= 1'b0;
      r_vic_dirty_p1 <= 1'b0;
      r_full_p1      <= 1'b0;
    end else begin
      r_vld_p1 <= w_accept_p0;
      if (w_accept_p0) begin
        r_hit_p1       <= w_hit_p0;
        r_way_p1       <= w_tgt_p0;
        r_vic_tag_p1   <= w_vic_tag_p0;
        r_vic_valid_p1 <= w_vic_valid_p0;
        r_vic_dirty_p1 <= w_vic_dirty_p0;
        r_full_p1      <= &w_valid_p0;
      end
      case (r_state)
        S_SWEEP: begin
          if (r_sweep_cnt == IW'(SETS - 1)) begin
            r_state     <= S_READY;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_sweep_cnt <= '0;
          end else begin
            r_sweep_cnt <= r_sweep_cnt + IW'(1);
          end
        end
        S_READY: begin
          if (bus.flush_i) begin
            r_state     <= S_SWEEP;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_sweep_cnt <= '0;
          end
        end
        default: r_state <= S_SWEEP;
      endcase
    end
  end

  assign bus.req_ready_o        = r_ready;
  assign bus.busy_o             = r_busy;
  assign bus.rsp_valid_o        = r_vld_p1;
  assign bus.rsp_hit_o          = r_hit_p1;
  assign bus.rsp_way_o          = r_way_p1;
  assign bus.rsp_victim_tag_o   = r_vic_tag_p1;
  assign bus.rsp_victim_valid_o = r_vic_valid_p1;
  assign bus.rsp_victim_dirty_o = r_vic_dirty_p1;
  assign bus.rsp_full_o         = r_full_p1;
endmodule

// File: doc/cache_tag_plru.md
CACHE_TAG_PLRU -- requirements
Module: cache_tag_plru

Interface
REQ-001 Parameter WAYS, default 4: associativity; power of two, 2..16.
REQ-002 Parameter SETS, default 1024: number of sets; power of two, at least 2.
REQ-003 Parameter TAG_W, default 20: stored tag width. Derived widths: IW=$clog2(SETS), WW=$clog2(WAYS).
REQ-004 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst_ni  in  1  reset, synchronous, active-low.
REQ-006 req_valid_i  in  1  request strobe.
REQ-007 req_ready_o  out  1  request accepted when req_valid_i and req_ready_o are both high.
REQ-008 req_op_i  in  2  operation: 00 LOOKUP, 01 LOOKUP_WR, 10 FILL, 11 INVAL.
REQ-009 req_index_i  in  IW  set index.
REQ-010 req_tag_i  in  TAG_W  tag to compare or store.
REQ-011 req_dirty_i  in  1  dirty value written by FILL.
REQ-012 flush_i  in  1  pulse; starts an invalidate-all sweep.
REQ-013 rsp_valid_o  out  1  one-cycle response strobe.
REQ-014 rsp_hit_o  out  1  the tag matched a valid way.
REQ-015 rsp_way_o  out  WW  hit way, or the way written on a FILL miss.
REQ-016 rsp_victim_tag_o  out  TAG_W  tag of the way replaced by the FILL.
REQ-017 rsp_victim_valid_o  out  1  the replaced way held a valid line.
REQ-018 rsp_victim_dirty_o  out  1  the replaced way was valid and dirty; writeback is needed.
REQ-019 rsp_full_o  out  1  all ways of the addressed set were valid before the operation.
REQ-020 busy_o  out  1  a sweep is in progress.

Function
REQ-021 State per set and way: tag, valid and dirty. State per set: WAYS-1 tree-PLRU bits.
REQ-022 FSM states:
- SWEEP: clears valid, dirty and PLRU bits of one set per cycle, with the counter running 0..SETS-1; goes to READY after set SETS-1.
- READY: accepts requests.
REQ-023 req_ready_o=1 only in READY; busy_o=1 only in SWEEP.
REQ-024 Latency: an accepted request produces rsp_valid_o exactly 1 cycle later. All rsp_* outputs are registered and hold their value until the next response.
REQ-025 Hit means tag equal and valid set. If more than one way hits, the lowest index wins.
REQ-026 LOOKUP:
- reports hit and way;
- on a hit, updates PLRU toward the hit way;
- on a miss, leaves state unchanged and rsp_way_o equals the would-be victim.
REQ-027 LOOKUP_WR: same as LOOKUP, and additionally sets dirty on the hit way.
REQ-028 FILL target selection:
- the hit way, if any;
- else the lowest-index invalid way;
- else the PLRU victim.
REQ-029 FILL writes tag=req_tag_i, valid=1, dirty=req_dirty_i to the target and updates PLRU toward the target.
REQ-030 FILL reports the target's prior contents on rsp_victim_*.
REQ-031 INVAL clears valid and dirty of the hit way. It reports the hit and the prior dirty bit on rsp_victim_dirty_o, and leaves PLRU unchanged.
REQ-032 PLRU tree update:
- node bit 0 means the victim lies in the lower half;
- on an access, every node on the path is set to point away from the accessed way;
- the victim is found by following the node bits from the root.
REQ-033 Only the addressed set is read or modified by a request.
REQ-034 flush_i in READY with a request accepted in the same cycle: the request completes normally, and SWEEP starts on the next cycle.
REQ-035 flush_i during SWEEP is ignored; the sweep is not restarted.
REQ-036 rsp_valid_o is 0 in every cycle without a completing request, including all SWEEP cycles after the first.
REQ-037 rsp_full_o is evaluated on the set state before the operation.

Reset
REQ-038 While rst_ni=0 on a clock edge:
- the FSM enters SWEEP with the counter at 0;
- rsp_valid_o, rsp_hit_o, rsp_victim_valid_o, rsp_victim_dirty_o and rsp_full_o go to 0;
- rsp_way_o and rsp_victim_tag_o go to 0.
REQ-039 Reset asserted during SWEEP restarts the sweep at set 0. Reset asserted during READY discards any response still pending.
REQ-040 req_ready_o first rises exactly SETS cycles after the first edge with rst_ni=1.

Verification (WAYS=4, SETS=1024, TAG_W=20)
REQ-041 Release reset and count cycles -> req_ready_o=0 for 1024 cycles, then 1; a LOOKUP of any set then misses.
REQ-042 FILL set 5 with tags 0x1,0x2,0x3,0x4 (dirty 0), then LOOKUP 0x1 -> fills land in ways 0,1,2,3; the 4th FILL has rsp_full_o=0; the lookup hits way 0.
REQ-043 Continue: LOOKUP_WR 0x3, then FILL 0x9 -> the victim is way 1 (tag 0x2, clean); a following FILL 0xA evicts way 3.
REQ-044 Set 7 full, LOOKUP_WR hits way 2, INVAL that tag -> rsp_victim_dirty_o=1; a following FILL picks way 2 (lowest invalid).
REQ-045 flush_i together with an accepted FILL -> the FILL response arrives, busy_o stays 1 for 1024 cycles, and all sets are empty afterwards.
REQ-046 Reset pulse at sweep counter 500 -> a full 1024-cycle sweep restarts and no rsp_valid_o pulse occurs.
